// File: rtl/memory_control.sv
// Memory arbiter between instruction and data caches and a single RAM port.
// Grants one access at a time, alternates on contention, and reports RAM
// errors or stalled accesses as a fault word plus a sticky ramerr flag.
module memory_control (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ramerr
);

  localparam logic [31:0] FAULT_WORD = 32'hBAD1BAD1;
  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [1:0]  RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;
  typedef enum logic {GRANT_DATA, GRANT_INSTR} grant_t;

  state_t      state, nxt;
  grant_t      last_grant;
  logic [7:0]  tmo;
  logic [31:0] ihold, dhold;
  logic        ilatch, dlatch, set_err;
  logic        dreq, fault;

  assign dreq  = dREN | dWEN;
  // A stalled access that has waited 255 cycles is treated like a RAM error.
  assign fault = (ramstate == RAM_ERROR) || (tmo == 8'hFF);

  // State register
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else       state <= nxt;

  // Remember who was granted last so contention alternates
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST)
      last_grant <= GRANT_INSTR;
    else if (state == IDLE && nxt != IDLE)
      last_grant <= (nxt == IACC) ? GRANT_INSTR : GRANT_DATA;

  // Timeout counter: held at 0 in IDLE so every access starts from 0, saturates at 255
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST)
      tmo <= '0;
    else if (state == IDLE)
      tmo <= '0;
    else if (ramstate != RAM_ACCESS && tmo != 8'hFF)
      tmo <= tmo + 8'd1;

  // Load hold registers capture whatever the load outputs show on completion/fault
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      ihold <= '0;
      dhold <= '0;
    end else begin
      if (ilatch) ihold <= iload;
      if (dlatch) dhold <= dload;
    end

  // Sticky fault flag, cleared only by reset
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST)        ramerr <= 1'b0;
    else if (set_err) ramerr <= 1'b1;

  // Next state and all RAM/cache-side outputs; abort is checked before fault/completion
  always_comb begin
    nxt      = state;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = ihold;
    dload    = dhold;
    ilatch   = 1'b0;
    dlatch   = 1'b0;
    set_err  = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && iREN) nxt = (last_grant == GRANT_INSTR) ? DACC : IACC;
        else if (dreq)    nxt = DACC;
        else if (iREN)    nxt = IACC;
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dreq) begin
          nxt = IDLE;
        end else if (fault) begin
          dwait   = 1'b0;
          dload   = FAULT_WORD;
          dlatch  = 1'b1;
          set_err = 1'b1;
          nxt     = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait = 1'b0;
          nxt   = IDLE;
          if (!dWEN) begin
            dload  = ramload;
            dlatch = 1'b1;
          end
        end
      end
      IACC: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (!iREN) begin
          nxt = IDLE;
        end else if (fault) begin
          iwait   = 1'b0;
          iload   = FAULT_WORD;
          ilatch  = 1'b1;
          set_err = 1'b1;
          nxt     = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait  = 1'b0;
          iload  = ramload;
          ilatch = 1'b1;
          nxt    = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_control.sv
// Self-checking bench for memory_control: directed scenarios plus a random
// run checked against a transaction-level model of the arbiter.
module tb_memory_control;

  localparam logic [31:0] BAD = 32'hBAD1BAD1;
  localparam logic [1:0]  FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        iwait, dwait, ramREN, ramWEN, ramerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0, errors = 0;

  memory_control dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- transaction-level reference model ----------------
  // owner: 0 = no access, 1 = data access, 2 = instruction access
  int          m_owner;
  int          m_waited;
  bit          m_instr_last;
  logic [31:0] m_ih, m_dh;
  bit          m_err;
  logic        e_iwait, e_dwait, e_ren, e_wen;
  logic [31:0] e_iload, e_dload, e_addr, e_store;

  task automatic model_reset();
    m_owner = 0; m_waited = 0; m_instr_last = 1; m_ih = '0; m_dh = '0; m_err = 0;
  endtask

  task automatic model_eval();
    bit req, timed_out;
    e_iwait = 1; e_dwait = 1; e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
    e_iload = m_ih; e_dload = m_dh;
    timed_out = (ramstate == ERROR) || (m_waited >= 255);
    if (m_owner == 1) begin
      req = dREN || dWEN;
      e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
      if (req && timed_out) begin e_dwait = 0; e_dload = BAD; end
      else if (req && ramstate == ACCESS) begin
        e_dwait = 0;
        if (!dWEN) e_dload = ramload;
      end
    end else if (m_owner == 2) begin
      e_addr = iaddr; e_ren = 1;
      if (iREN && timed_out) begin e_iwait = 0; e_iload = BAD; end
      else if (iREN && ramstate == ACCESS) begin e_iwait = 0; e_iload = ramload; end
    end
  endtask

  task automatic model_step();
    bit req, timed_out;
    timed_out = (ramstate == ERROR) || (m_waited >= 255);
    if (m_owner == 0) begin
      req = dREN || dWEN;
      if (req && iREN) m_owner = m_instr_last ? 1 : 2;
      else if (req)    m_owner = 1;
      else if (iREN)   m_owner = 2;
      if (m_owner != 0) begin m_waited = 0; m_instr_last = (m_owner == 2); end
    end else begin
      req = (m_owner == 1) ? (dREN || dWEN) : iREN;
      if (!req) m_owner = 0;
      else if (timed_out) begin
        if (m_owner == 1) m_dh = BAD; else m_ih = BAD;
        m_err = 1; m_owner = 0;
      end else if (ramstate == ACCESS) begin
        if (m_owner == 1 && !dWEN) m_dh = ramload;
        if (m_owner == 2) m_ih = ramload;
        m_owner = 0;
      end else if (m_waited < 255) m_waited++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clk1();
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    clk1();
    nRST = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nRST = 0; iREN = 1; dREN = 1; dWEN = 1; daddr = 32'h1234; dstore = 32'h5678;
    iaddr = 32'h9; ramstate = ACCESS; ramload = 32'hFFFF_FFFF;
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, ramerr} !== 5'b11000) begin
      errors++; $display("FAIL reset_ctl: got %b want 11000", {iwait, dwait, ramREN, ramWEN, ramerr});
    end
    checks++;
    if (ramaddr !== 0 || ramstore !== 0 || iload !== 0 || dload !== 0) begin
      errors++; $display("FAIL reset_data: addr %h store %h iload %h dload %h want all 0", ramaddr, ramstore, iload, dload);
    end
    clk1(); clk1();
    checks++;
    if (dwait !== 1 || ramWEN !== 0) begin
      errors++; $display("FAIL reset_hold: dwait %b ramWEN %b want 1 0", dwait, ramWEN);
    end
    idle_inputs();
    nRST = 1;
    clk1();
  endtask

  task automatic test_fetch();
    iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h2001000A;
    @(negedge CLK);
    checks++;
    if (iwait !== 1 || ramREN !== 0) begin
      errors++; $display("FAIL fetch_cycle1: iwait %b ramREN %b want 1 0", iwait, ramREN);
    end
    clk1();
    @(negedge CLK);
    checks++;
    if (iwait !== 0 || iload !== 32'h2001000A || ramREN !== 1 || ramaddr !== 32'h40) begin
      errors++; $display("FAIL fetch_cycle2: iwait %b iload %h ramREN %b addr %h want 0 2001000a 1 40", iwait, iload, ramREN, ramaddr);
    end
    clk1();
    iREN = 0; ramload = 32'h12345678;
    @(negedge CLK);
    checks++;
    if (iwait !== 1 || iload !== 32'h2001000A) begin
      errors++; $display("FAIL fetch_hold: iwait %b iload %h want 1 2001000a", iwait, iload);
    end
    clk1();
  endtask

  logic [31:0] last_dread;

  task automatic test_simultaneous();
    int ed[6] = '{1, 0, 1, 1, 1, 0};
    int ei[6] = '{1, 1, 1, 0, 1, 1};
    iREN = 1; dREN = 1; dWEN = 0; ramstate = ACCESS; ramload = $urandom;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checks++;
      if (dwait !== ed[i][0] || iwait !== ei[i][0]) begin
        errors++; $display("FAIL simul_grant[%0d]: dwait %b iwait %b want %0d %0d", i, dwait, iwait, ed[i], ei[i]);
      end
      if (ed[i] == 0) begin
        last_dread = ramload;
        checks++;
        if (dload !== ramload) begin
          errors++; $display("FAIL simul_dload[%0d]: got %h want %h", i, dload, ramload);
        end
      end
      clk1();
      ramload = $urandom;
    end
    idle_inputs();
    clk1();
  endtask

  task automatic test_write();
    dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF; ramstate = ACCESS; ramload = 32'h0BADF00D;
    @(negedge CLK);
    checks++;
    if (ramWEN !== 0 || dwait !== 1) begin
      errors++; $display("FAIL write_idle: ramWEN %b dwait %b want 0 1", ramWEN, dwait);
    end
    clk1();
    @(negedge CLK);
    checks++;
    if ({ramWEN, ramREN, dwait} !== 3'b100 || ramaddr !== 32'h80 || ramstore !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_access: wen/ren/dwait %b addr %h store %h want 100 80 deadbeef", {ramWEN, ramREN, dwait}, ramaddr, ramstore);
    end
    checks++;
    if (dload !== last_dread) begin
      errors++; $display("FAIL write_dload: got %h want %h", dload, last_dread);
    end
    clk1();
    idle_inputs();
    clk1();
  endtask

  task automatic test_error_abort();
    checks++;
    if (ramerr !== 0) begin errors++; $display("FAIL err_pre: ramerr %b want 0", ramerr); end
    iREN = 1; iaddr = $urandom; ramstate = BUSY;
    @(negedge CLK);
    clk1();
    ramstate = ERROR;
    @(negedge CLK);
    checks++;
    if (iwait !== 0 || iload !== BAD) begin
      errors++; $display("FAIL err_iacc: iwait %b iload %h want 0 bad1bad1", iwait, iload);
    end
    clk1();
    idle_inputs();
    @(negedge CLK);
    checks++;
    if (ramerr !== 1 || iload !== BAD) begin
      errors++; $display("FAIL err_sticky: ramerr %b iload %h want 1 bad1bad1", ramerr, iload);
    end
    clk1();
    // good fetch to load a known hold value
    iREN = 1; ramstate = ACCESS; ramload = 32'hCAFE0001;
    clk1(); clk1();
    idle_inputs();
    clk1();
    // abort: request dropped mid-access while RAM reports ACCESS
    iREN = 1; ramstate = BUSY;
    clk1();
    @(negedge CLK);
    checks++;
    if (iwait !== 1 || ramREN !== 1) begin
      errors++; $display("FAIL abort_busy: iwait %b ramREN %b want 1 1", iwait, ramREN);
    end
    clk1();
    iREN = 0; ramstate = ACCESS; ramload = 32'h00000055;
    @(negedge CLK);
    checks++;
    if (iwait !== 1 || iload !== 32'hCAFE0001) begin
      errors++; $display("FAIL abort_cycle: iwait %b iload %h want 1 cafe0001", iwait, iload);
    end
    clk1();
    @(negedge CLK);
    checks++;
    if (ramREN !== 0 || iload !== 32'hCAFE0001) begin
      errors++; $display("FAIL abort_idle: ramREN %b iload %h want 0 cafe0001", ramREN, iload);
    end
    clk1();
  endtask

  task automatic test_timeout();
    int hit = 0;
    do_reset();
    checks++;
    if (ramerr !== 0) begin errors++; $display("FAIL tmo_pre: ramerr %b want 0", ramerr); end
    dREN = 1; dWEN = 0; daddr = 32'h100; ramstate = BUSY;
    @(negedge CLK);
    clk1();
    for (int n = 1; n <= 300; n++) begin
      @(negedge CLK);
      if (dwait === 1'b0) begin hit = n; break; end
      clk1();
    end
    checks++;
    if (hit != 256 || dload !== BAD) begin
      errors++; $display("FAIL tmo_cycle: first dwait=0 at DACC cycle %0d dload %h want 256 bad1bad1", hit, dload);
    end
    clk1();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checks++;
      if (ramerr !== 1 || dload !== BAD) begin
        errors++; $display("FAIL tmo_sticky[%0d]: ramerr %b dload %h want 1 bad1bad1", k, ramerr, dload);
      end
      clk1();
    end
  endtask

  task automatic test_async_reset();
    dREN = 1; dWEN = 0; daddr = 32'h44; ramstate = BUSY;
    clk1();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1 || ramaddr !== 32'h44) begin
      errors++; $display("FAIL areset_pre: ramREN %b addr %h want 1 44", ramREN, ramaddr);
    end
    #1 nRST = 0;
    #1;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, ramerr} !== 5'b11000 || ramaddr !== 0 || dload !== 0) begin
      errors++; $display("FAIL areset_now: ctl %b addr %h dload %h want 11000 0 0", {iwait, dwait, ramREN, ramWEN, ramerr}, ramaddr, dload);
    end
    ramstate = ACCESS; ramload = 32'h77;
    clk1();
    checks++;
    if (dwait !== 1 || dload !== 0) begin
      errors++; $display("FAIL areset_nopulse: dwait %b dload %h want 1 0", dwait, dload);
    end
    idle_inputs();
    nRST = 1;
    clk1();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      iREN = ($urandom_range(0, 9) < 6);
      dREN = ($urandom_range(0, 9) < 5);
      dWEN = ($urandom_range(0, 9) < 3);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      r = $urandom_range(0, 99);
      ramstate = (r < 40) ? ACCESS : (r < 75) ? BUSY : (r < 92) ? FREE : ERROR;
      @(negedge CLK);
      model_eval();
      checks++;
      if ({iwait, dwait, ramREN, ramWEN} !== {e_iwait, e_dwait, e_ren, e_wen}) begin
        errors++; $display("FAIL rnd_ctl[%0d]: iwait/dwait/ren/wen %b want %b", c, {iwait, dwait, ramREN, ramWEN}, {e_iwait, e_dwait, e_ren, e_wen});
      end
      checks++;
      if (ramaddr !== e_addr || ramstore !== e_store) begin
        errors++; $display("FAIL rnd_ram[%0d]: addr %h store %h want %h %h", c, ramaddr, ramstore, e_addr, e_store);
      end
      checks++;
      if (iload !== e_iload || dload !== e_dload) begin
        errors++; $display("FAIL rnd_load[%0d]: iload %h dload %h want %h %h", c, iload, dload, e_iload, e_dload);
      end
      checks++;
      if (ramerr !== m_err) begin
        errors++; $display("FAIL rnd_err[%0d]: ramerr %b want %b", c, ramerr, m_err);
      end
      model_step();
      clk1();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_write();
    test_error_abort();
    test_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_control.md
MEMORY_CONTROL -- requirements
Module: memory_control

Interface
REQ-001 The block SHALL have these ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request from caches
- dREN  in  1  data read request from caches
- dWEN  in  1  data write request from caches
- iaddr  in  32  instruction address
- daddr  in  32  data address
- dstore  in  32  data write value
- iwait  out  1  instruction not complete
- dwait  out  1  data not complete
- iload  out  32  instruction read value
- dload  out  32  data read value
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write value
- ramload  in  32  RAM read value
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ramerr  out  1  sticky fault flag
REQ-002 There SHALL be one clock; reset is asynchronous and active-low (CLK, nRST).

Function
REQ-003 The FSM SHALL have three registered states: IDLE, DACC and IACC.
REQ-004 In IDLE, ramREN and ramWEN SHALL both be 0, and iwait and dwait SHALL both be 1.
REQ-005 From IDLE, when only a data request (dREN or dWEN) is pending, the next state SHALL be DACC; when only iREN is pending, it SHALL be IACC.
REQ-006 From IDLE with data and instruction requests both pending, grant SHALL alternate on a registered last_grant bit: DACC if last_grant=INSTR, else IACC.
REQ-007 last_grant SHALL update on entry to DACC or IACC.
REQ-008 In DACC, ramaddr SHALL be daddr, ramstore SHALL be dstore, ramWEN SHALL be dWEN, and ramREN SHALL be dREN and not dWEN (write wins when both are high).
REQ-009 In IACC, ramaddr SHALL be iaddr, ramREN SHALL be 1 and ramWEN SHALL be 0.
REQ-010 In IDLE, ramaddr and ramstore SHALL be 0.
REQ-011 Completion: when in DACC (IACC) with ramstate=ACCESS, dwait (iwait) SHALL be 0 in that same cycle and the next state SHALL be IDLE.
REQ-012 On a DACC read completion, dload SHALL equal ramload combinationally and SHALL be latched into a hold register.
REQ-013 On an IACC completion, iload SHALL equal ramload combinationally and SHALL be latched into a hold register.
REQ-014 At all other times, iload and dload SHALL present their hold registers.
REQ-015 The wait output of the non-granted port SHALL remain 1.
REQ-016 Minimum latency SHALL be 2 cycles (request in IDLE cycle; completion in the next cycle if ramstate=ACCESS).
REQ-017 On entry to DACC or IACC, an 8-bit timeout counter SHALL clear to 0.
REQ-018 The timeout counter SHALL increment each access-state cycle with ramstate not equal to ACCESS, and SHALL saturate at 255.
REQ-019 Fault: in an access state, if ramstate=ERROR or the counter equals 255, the block SHALL:
- drive the active wait output to 0 that cycle;
- drive the active load output to 0xBAD1BAD1 and latch that value into its hold register;
- set ramerr (sticky until reset);
- go to IDLE.
REQ-020 Abort: in DACC with dREN=dWEN=0, or in IACC with iREN=0, the next state SHALL be IDLE, with no completion and hold registers unchanged.
REQ-021 Abort SHALL take precedence over completion and fault in the same cycle.
REQ-022 A request that remains asserted after completion SHALL be treated as a new request from IDLE (one dead cycle between accesses).

Reset
REQ-023 nRST low SHALL asynchronously force state=IDLE, last_grant=INSTR, timeout counter=0, iload and dload hold registers=0, and ramerr=0.
REQ-024 Consequently, during reset outputs SHALL be iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0 and iload=dload=0.
REQ-025 Reset asserted mid-access SHALL abandon the access with no completion pulse.

Verification
REQ-026 Instruction fetch: iREN=1, iaddr=0x40, ramstate=ACCESS, ramload=0x2001000A -> iwait=0 on cycle 2, iload=0x2001000A; iload holds the value after iREN drops.
REQ-027 Simultaneous requests: iREN=dREN=1 with ramstate=ACCESS -> data granted first, then instruction, then data again (alternation), with one IDLE cycle between each.
REQ-028 Write priority: dREN=dWEN=1, daddr=0x80, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramaddr=0x80, ramstore=0xDEADBEEF; dwait=0 on the first ACCESS cycle.
REQ-029 Timeout: dREN=1 with ramstate held BUSY -> dwait=0 after 255 BUSY cycles in DACC, dload=0xBAD1BAD1, ramerr=1 and remains 1.
REQ-030 ERROR and abort: ramstate=ERROR during IACC -> iwait=0, iload=0xBAD1BAD1, ramerr=1; separately, iREN dropping while BUSY -> IDLE with iwait=1 and iload unchanged.
REQ-031 Async reset: nRST pulsed low mid-DACC between clock edges -> outputs go to reset values immediately, with no dwait=0 pulse.
